// File: rtl/binary_to_gray_pkg.sv
// -----------------------------------------------------------------------------
// binary_to_gray_pkg
//
// Purpose:
//    Shared constants and conversion helpers for the binary-to-Gray converter.
//    The helpers work on a fixed wide vector (GRAY_WIDTH_MAX bits). Callers
//    zero-extend their operand into it and truncate the result back to their
//    own width. Zero-extension keeps both conversions exact for any
//    WIDTH <= GRAY_WIDTH_MAX, because the extra upper bits stay zero.
//
// Contents:
//    GRAY_WIDTH_DEFAULT : standard converter width (4 bits).
//    GRAY_WIDTH_MAX     : widest width the helpers support.
//    bin2gray(value)    : reflected Gray code, value ^ (value >> 1).
//    gray2bin(value)    : inverse conversion, prefix XOR from the MSB downward.
// -----------------------------------------------------------------------------
package binary_to_gray_pkg;

   localparam int GRAY_WIDTH_DEFAULT = 4;
   localparam int GRAY_WIDTH_MAX     = 64;

   typedef logic [GRAY_WIDTH_MAX-1:0] gray_word_t;

   // Logical shift: the MSB of the Gray code equals the MSB of the binary
   // input, and each lower bit is the XOR of two adjacent binary bits.
   function automatic gray_word_t bin2gray(input gray_word_t value);
      return value ^ (value >> 1);
   endfunction

   // Each binary bit is the XOR of every Gray bit at or above its position.
   // Walking downward from the MSB reuses the running result.
   function automatic gray_word_t gray2bin(input gray_word_t value);
      gray_word_t result;
      result[GRAY_WIDTH_MAX-1] = value[GRAY_WIDTH_MAX-1];
      for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
         result[i] = result[i+1] ^ value[i];
      end
      return result;
   endfunction

endpackage : binary_to_gray_pkg

// File: rtl/gray_to_binary.sv
// -----------------------------------------------------------------------------
// gray_to_binary
//
// Purpose:
//    Purely combinational reflected-Gray-to-binary decoder. It is used by the
//    converter's optional round-trip checker (BTG_SELF_CHECK_EN).
//
// Parameters:
//    WIDTH     : code width, 1 .. GRAY_WIDTH_MAX.
//
// Ports:
//    i_gray    : input  [WIDTH-1:0] Gray-coded value.
//    o_binary  : output [WIDTH-1:0] equivalent unsigned binary value.
// -----------------------------------------------------------------------------
module gray_to_binary
   import binary_to_gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_binary
);

   // Zero-extending into the wide helper leaves the prefix XOR unchanged in
   // the low WIDTH bits, so truncating the result gives the exact answer.
   assign o_binary = WIDTH'(gray2bin(GRAY_WIDTH_MAX'(i_gray)));

endmodule : gray_to_binary

// File: rtl/binary_to_gray.sv
// -----------------------------------------------------------------------------
// binary_to_gray
//
// Purpose:
//    Registered binary-to-reflected-Gray-code converter with a valid
//    qualifier. It sits ahead of clock-domain crossings and position encoders.
//    The data path is combinational XOR logic followed by one register stage,
//    so every accepted input produces its result exactly one clock later.
//    There is no backpressure: every valid input is accepted, and back-to-back
//    valid inputs produce one result per cycle.
//
// Parameters:
//    WIDTH      : width of binary_in and gray_out (1 .. GRAY_WIDTH_MAX).
//
// Ports:
//    clk        : input,  single clock; all state updates on its rising edge.
//    rst        : input,  synchronous active-high reset. It takes priority
//                 over in_valid.
//    binary_in  : input  [WIDTH-1:0], unsigned binary value to convert.
//    in_valid   : input,  binary_in is valid this cycle.
//    gray_out   : output [WIDTH-1:0], registered Gray code of the last
//                 accepted binary_in. It holds while in_valid is low.
//    out_valid  : output, gray_out was updated on the previous edge.
//    check_err  : output (BTG_SELF_CHECK_EN only). Registered, sticky
//                 round-trip error flag, cleared only by rst.
//
// Configuration:
//    BTG_SELF_CHECK_EN : when defined, adds a shadow copy of each accepted
//                        input. It also decodes gray_out back to binary and
//                        flags any disagreement on check_err. The core data
//                        path is the same in both builds.
// -----------------------------------------------------------------------------
module binary_to_gray
   import binary_to_gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] binary_in,
   input  logic             in_valid,
   output logic [WIDTH-1:0] gray_out,
   output logic             out_valid
`ifdef BTG_SELF_CHECK_EN
   ,
   output logic             check_err
`endif
);

   // --------------------------------------------------------------------------
   // Core data path: XOR encode, then one register stage.
   // --------------------------------------------------------------------------
   logic [WIDTH-1:0] w_gray_next;
   logic [WIDTH-1:0] r_gray_out;
   logic             r_out_valid;

   assign w_gray_next = WIDTH'(bin2gray(GRAY_WIDTH_MAX'(binary_in)));

   // Reset wins over in_valid, so an input sampled on a reset edge is dropped.
   // When in_valid is low, the code holds and only the qualifier drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gray_out  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         // NOTE: registers use non-blocking assignments so every flop samples
         // the values from before the edge, whatever the statement order.
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_gray_out <= w_gray_next;
         end
      end
   end

   assign gray_out  = r_gray_out;
   assign out_valid = r_out_valid;

`ifdef BTG_SELF_CHECK_EN
   // --------------------------------------------------------------------------
   // Round-trip checker: decode the registered code and compare it with a
   // shadow of the binary value that produced it.
   // --------------------------------------------------------------------------
   logic [WIDTH-1:0] r_shadow_bin;
   logic [WIDTH-1:0] w_roundtrip_bin;
   logic             w_mismatch;
   logic             r_check_err;

   gray_to_binary #(
      .WIDTH    (WIDTH)
   ) u_gray_to_binary (
      .i_gray   (r_gray_out),
      .o_binary (w_roundtrip_bin)
   );

   // Compare only while out_valid is high. During hold cycles the shadow and
   // the code are both stale but still consistent.
   assign w_mismatch = r_out_valid && (w_roundtrip_bin != r_shadow_bin);

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the shadow is reset along with the flag, so the comparison
         // never sees X, even before the first accepted input.
         r_shadow_bin <= '0;
         r_check_err  <= 1'b0;
      end else begin
         if (in_valid) begin
            r_shadow_bin <= binary_in;
         end
         if (w_mismatch) begin
            r_check_err <= 1'b1;
         end
      end
   end

   assign check_err = r_check_err;
`endif

endmodule : binary_to_gray

// File: tb/tb_binary_to_gray.sv
// -----------------------------------------------------------------------------
// tb_binary_to_gray
//
// Scoreboard bench for binary_to_gray. The stimulus process pushes the
// hand-computed Gray code for every accepted input into a queue. A separate
// monitor pops and compares on every cycle in which out_valid is high.
// Idle, hold and reset behaviour is checked directly by the stimulus process.
// With BTG_SELF_CHECK_EN defined, the bench runs at WIDTH=8. It then adds a
// random stream and checks check_err.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_binary_to_gray;
   import binary_to_gray_pkg::*;

`ifdef BTG_SELF_CHECK_EN
   localparam int W = 8;
`else
   localparam int W = GRAY_WIDTH_DEFAULT;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] binary_in;
   logic         in_valid;
   logic [W-1:0] gray_out;
   logic         out_valid;
`ifdef BTG_SELF_CHECK_EN
   logic         check_err;
`endif

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [W-1:0] exp_q   [$];
   logic [W-1:0] obs_log [$];

   // Reflected Gray codes of 0..15, worked out by hand.
   logic [3:0] sweep_gray [16] = '{
      4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
      4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
   };

   always #5 clk = ~clk;

   binary_to_gray #(
      .WIDTH     (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .binary_in (binary_in),
      .in_valid  (in_valid),
      .gray_out  (gray_out),
      .out_valid (out_valid)
`ifdef BTG_SELF_CHECK_EN
      ,
      .check_err (check_err)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Drives one cycle of inputs at a negedge and returns on the next negedge,
   // after the rising edge that sampled them. e is the expected Gray code.
   task automatic cyc(input logic r, input logic v, input logic [W-1:0] b, input logic [W-1:0] e);
      rst       = r;
      in_valid  = v;
      binary_in = b;
      if (v && !r) exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: on each cycle with out_valid high, it pops one expected code and
   // compares it with gray_out.
   initial begin : monitor
      logic [W-1:0] exp_val;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            obs_log.push_back(gray_out);
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
               exp_val = exp_q.pop_front();
               check("gray_out", 64'(gray_out), 64'(exp_val));
            end
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1; in_valid = 1'b0; binary_in = '0;

      // Reset held for 2 cycles, then idle.
      cyc(1'b1, 1'b0, '0, '0);
      cyc(1'b1, 1'b0, '0, '0);
      check("reset_gray_out", 64'(gray_out), 64'(0));
      check("reset_out_valid", 64'(out_valid), 64'(0));
`ifdef BTG_SELF_CHECK_EN
      check("reset_check_err", 64'(check_err), 64'(0));
`endif
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, '0, '0);
         check("idle_gray_out", 64'(gray_out), 64'(0));
         check("idle_out_valid", 64'(out_valid), 64'(0));
      end

      // Full sweep 0..15, then wrap to 0, back to back.
      obs_log.delete();
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, W'(i), W'(sweep_gray[i]));
      end
      cyc(1'b0, 1'b1, '0, '0);
      cyc(1'b0, 1'b0, '0, '0);
      cyc(1'b0, 1'b0, '0, '0);
      check("sweep_result_count", 64'(obs_log.size()), 64'(17));
      if (obs_log.size() == 17) begin
         for (int i = 1; i < 17; i++) begin
            check("single_bit_step", 64'($countones(obs_log[i-1] ^ obs_log[i])), 64'(1));
         end
      end

      // Hold: one valid input, then 3 invalid cycles with different data.
      cyc(1'b0, 1'b1, W'(4'b1010), W'(4'b1111));
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, W'(4'b0101), '0);
         check("hold_gray_out", 64'(gray_out), 64'(W'(4'b1111)));
         check("hold_out_valid", 64'(out_valid), 64'(0));
      end

      // Reset mid-stream: the input sampled with rst high is discarded.
      cyc(1'b0, 1'b1, W'(4'b0011), W'(4'b0010));
      cyc(1'b1, 1'b1, W'(4'b0111), '0);
      check("midrst_gray_out", 64'(gray_out), 64'(0));
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      cyc(1'b0, 1'b0, '0, '0);
      check("post_rst_gray_out", 64'(gray_out), 64'(0));
      check("post_rst_out_valid", 64'(out_valid), 64'(0));

`ifdef BTG_SELF_CHECK_EN
      // Wide build: a directed vector, then a random stream.
      cyc(1'b0, 1'b1, 8'hA5, 8'hF7);
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] b;
         b = W'($urandom_range(0, (1 << W) - 1));
         cyc(1'b0, 1'b1, b, b ^ (b >> 1));
      end
      cyc(1'b0, 1'b0, '0, '0);
      cyc(1'b0, 1'b0, '0, '0);
      check("check_err_after_stream", 64'(check_err), 64'(0));
`endif

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule : tb_binary_to_gray

// File: doc/binary_to_gray.md
Name: binary_to_gray

Overview:
Registered binary-to-reflected-Gray-code converter with a valid qualifier. It is used ahead of clock-domain crossings and position encoders, where only one bit may change between successive codes. The data path is purely combinational XOR logic followed by one output register stage, so results appear one cycle after input. The width is parameterised; the default of 4 bits is the standard configuration.

Parameters:
WIDTH, 4, bit width of the binary input and the Gray output (must be at least 1).

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  reset, synchronous, active-high.
binary_in  input  WIDTH  unsigned binary value to convert.
in_valid  input  1  binary_in is valid this cycle.
gray_out  output  WIDTH  registered Gray code of the last accepted binary_in.
out_valid  output  1  gray_out was updated on the previous edge.

Behaviour:
- Conversion: gray[WIDTH-1] = bin[WIDTH-1]; for i < WIDTH-1, gray[i] = bin[i+1] XOR bin[i]. This is equivalent to bin XOR (bin >> 1), a logical shift.
- Latency: exactly 1 clock. If in_valid=1 at edge N, then gray_out = f(binary_in sampled at N) and out_valid=1 after edge N.
- If in_valid=0 at an edge: gray_out holds its previous value and out_valid goes to 0.
- No backpressure. Every valid input is accepted, and back-to-back valids give one result per cycle.
- Reset: while rst=1 at an edge, gray_out <= 0 and out_valid <= 0. Reset takes priority over in_valid. Reset asserted mid-stream discards the input sampled on that edge.
- Output after reset with no valid input: gray_out = 0 and out_valid = 0, stable indefinitely.
- Wrap-around: consecutive binary values differ in exactly one Gray bit, including the wrap from 2^WIDTH-1 to 0 (4'b1000 -> 4'b0000 for WIDTH=4).
- There are no X propagations from reset. Outputs are fully defined from the first reset edge onward.
- WIDTH=1: gray_out = binary_in, registered.

Optional Feature:
Macro BTG_SELF_CHECK_EN.
- When defined: add output check_err (1 bit, registered).
  - The registered gray_out is converted back to binary combinationally and compared against a shadow register of the accepted binary_in.
  - check_err=1 in any cycle where out_valid=1 and the round-trip mismatches; otherwise check_err=0.
  - Reset value of check_err is 0.
  - It is sticky until rst.
- When undefined: no check_err port, no shadow register, no inverse logic.
- The core data path is identical in both builds.

Decomposition:
- Package binary_to_gray_pkg holds:
  - the default width constant GRAY_WIDTH_DEFAULT = 4;
  - a function bin2gray(value) used by the core;
  - a function gray2bin(value), prefix XOR from the MSB downward, used by the checker and by benches.
- One natural sub-module: gray_to_binary (combinational, WIDTH parameter), instantiated only under BTG_SELF_CHECK_EN.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release, keep in_valid=0 -> gray_out=4'b0000 and out_valid=0 every cycle.
- Full sweep: feed binary_in 0..15, one per cycle with in_valid=1 -> one cycle later gray_out = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
- Single-bit-change check: during the sweep plus wrap 15->0, the popcount of XOR between successive gray_out values is 1 every time (1000 -> 0000 included).
- Hold: send 4'b1010 valid, then in_valid=0 for 3 cycles with binary_in=4'b0101 -> gray_out stays 4'b1111 and out_valid=0 after the first cycle.
- Reset mid-stream: rst=1 on the same edge as binary_in=4'b0111 with in_valid=1 -> gray_out=4'b0000 and out_valid=0 (not 4'b0100).
- Self-check build (BTG_SELF_CHECK_EN, WIDTH=8): random stream of 1000 valid values -> check_err stays 0, and every gray_out equals bin XOR (bin>>1), e.g. 8'hA5 -> 8'hF7.
